// File: rtl/param_universal_shift_reg.sv
// Universal shift register with single-step operations and counted shift bursts.
// A two-state controller (IDLE/BUSY) sequences bursts and pulses done on completion.
module param_universal_shift_reg #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic             serial_in_left,
  input  logic             serial_in_right,
  input  logic [WIDTH-1:0] parallel_load,
  input  logic             start,
  input  logic [CNT_W-1:0] shift_count,
  output logic [WIDTH-1:0] q,
  output logic             serial_out_left,
  output logic             serial_out_right,
  output logic             busy,
  output logic             done
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_SHR  = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_LOAD = 3'b011;
  localparam logic [2:0] MODE_ROTR = 3'b100;
  localparam logic [2:0] MODE_ROTL = 3'b101;
  localparam logic [2:0] MODE_ASR  = 3'b110;
  localparam logic [2:0] MODE_CLR  = 3'b111;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       mode_q, mode_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  function automatic logic is_shift_class(input logic [2:0] m);
    case (m)
      MODE_SHR, MODE_SHL, MODE_ROTR, MODE_ROTL, MODE_ASR: is_shift_class = 1'b1;
      default:                                            is_shift_class = 1'b0;
    endcase
  endfunction

  function automatic logic [WIDTH-1:0] apply_op(
    input logic [2:0]       m,
    input logic [WIDTH-1:0] v,
    input logic             sil,
    input logic             sir,
    input logic [WIDTH-1:0] pl
  );
    case (m)
      MODE_HOLD: apply_op = v;
      MODE_SHR:  apply_op = {sir, v[WIDTH-1:1]};
      MODE_SHL:  apply_op = {v[WIDTH-2:0], sil};
      MODE_LOAD: apply_op = pl;
      MODE_ROTR: apply_op = {v[0], v[WIDTH-1:1]};
      MODE_ROTL: apply_op = {v[WIDTH-2:0], v[WIDTH-1]};
      MODE_ASR:  apply_op = {v[WIDTH-1], v[WIDTH-1:1]};
      MODE_CLR:  apply_op = '0;
      default:   apply_op = v;
    endcase
  endfunction

  // Next-state: burst requests win over single steps; done marks the edge a request completes.
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (is_shift_class(mode) && (shift_count != '0)) begin
            state_d = ST_BUSY;
            mode_d  = mode;
            cnt_d   = shift_count;
            busy_d  = 1'b1;
          end else begin
            done_d  = 1'b1;
          end
        end else if (en) begin
          q_d = apply_op(mode, q_q, serial_in_left, serial_in_right, parallel_load);
        end else begin
          q_d = q_q;
        end
      end
      ST_BUSY: begin
        q_d   = apply_op(mode_q, q_q, serial_in_left, serial_in_right, parallel_load);
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          busy_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State and output registers; reset clears everything immediately, aborting any burst.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      q_q     <= '0;
      cnt_q   <= '0;
      mode_q  <= MODE_HOLD;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign q                = q_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign serial_out_left  = q_q[WIDTH-1];
  assign serial_out_right = q_q[0];

endmodule

// File: tb/tb_param_universal_shift_reg.sv
// Self-checking bench for param_universal_shift_reg (WIDTH=8, CNT_W=4):
// directed scenarios plus randomized steps and bursts against an arithmetic reference model.
module tb_param_universal_shift_reg;

  logic       clk;
  logic       rst;
  logic       en;
  logic [2:0] mode;
  logic       serial_in_left;
  logic       serial_in_right;
  logic [7:0] parallel_load;
  logic       start;
  logic [3:0] shift_count;
  logic [7:0] q;
  logic       serial_out_left;
  logic       serial_out_right;
  logic       busy;
  logic       done;

  int         pass_cnt;
  int         total_cnt;
  logic [7:0] exp_q;

  param_universal_shift_reg #(.WIDTH(8), .CNT_W(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .en              (en),
    .mode            (mode),
    .serial_in_left  (serial_in_left),
    .serial_in_right (serial_in_right),
    .parallel_load   (parallel_load),
    .start           (start),
    .shift_count     (shift_count),
    .q               (q),
    .serial_out_left (serial_out_left),
    .serial_out_right(serial_out_right),
    .busy            (busy),
    .done            (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: each mode expressed as integer arithmetic on the register value.
  function automatic logic [7:0] ref_op(input logic [2:0] m, input logic [7:0] v,
                                        input logic sil, input logic sir, input logic [7:0] pl);
    int u;
    u = int'(v);
    case (m)
      3'd0:    return v;
      3'd1:    return 8'((u / 2) + (sir ? 128 : 0));
      3'd2:    return 8'(((u * 2) % 256) + int'(sil));
      3'd3:    return pl;
      3'd4:    return 8'((u / 2) + (u % 2) * 128);
      3'd5:    return 8'(((u * 2) % 256) + (u / 128));
      3'd6:    return 8'((u / 2) + ((u >= 128) ? 128 : 0));
      default: return 8'd0;
    endcase
  endfunction

  function automatic logic [2:0] pick_shift_mode();
    logic [2:0] sc [5];
    sc = '{3'd1, 3'd2, 3'd4, 3'd5, 3'd6};
    return sc[$urandom_range(0, 4)];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_q(input logic [7:0] v);
    start = 1'b0; en = 1'b1; mode = 3'd3; parallel_load = v;
    tick();
    en = 1'b0; mode = 3'd0;
    exp_q = v;
  endtask

  task automatic test_reset();
    rst = 1'b0; en = 1'b0; mode = 3'd0; start = 1'b0; shift_count = 4'd0;
    serial_in_left = 1'b0; serial_in_right = 1'b0; parallel_load = 8'd0;
    #2;
    total_cnt++;
    if ({q, busy, done} !== 10'd0) $display("FAIL reset_state q=%h busy=%b done=%b want 00/0/0", q, busy, done);
    else pass_cnt++;
    @(posedge clk); #1;
    rst = 1'b1;
    exp_q = 8'd0;
  endtask

  task automatic test_async_reset();
    load_q(8'h3C);
    total_cnt++;
    if (q !== 8'h3C) $display("FAIL async_reset_preload q=%h want 3c", q);
    else pass_cnt++;
    #2; rst = 1'b0; #1;
    total_cnt++;
    if ({q, busy, done} !== 10'd0) $display("FAIL async_reset q=%h busy=%b done=%b want 00/0/0", q, busy, done);
    else pass_cnt++;
    rst = 1'b1;
    exp_q = 8'd0;
  endtask

  task automatic test_load_hold();
    load_q(8'hA5);
    total_cnt++;
    if (q !== 8'hA5) $display("FAIL load q=%h want a5", q);
    else pass_cnt++;
    en = 1'b1; mode = 3'd0;
    for (int i = 0; i < 3; i++) begin
      tick();
      total_cnt++;
      if (q !== 8'hA5) $display("FAIL hold q=%h want a5", q);
      else pass_cnt++;
    end
    en = 1'b0; mode = 3'd7;
    tick();
    total_cnt++;
    if (q !== 8'hA5) $display("FAIL en_low q=%h want a5", q);
    else pass_cnt++;
  endtask

  task automatic test_single_steps();
    logic [2:0] ms [4];
    logic [7:0] ev [4];
    ms = '{3'd4, 3'd5, 3'd6, 3'd1};
    ev = '{8'hD2, 8'hA5, 8'hD2, 8'h69};
    en = 1'b1; serial_in_right = 1'b0; serial_in_left = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mode = ms[i];
      tick();
      total_cnt++;
      if (q !== ev[i]) $display("FAIL step_mode%0d q=%h want %h", ms[i], q, ev[i]);
      else pass_cnt++;
    end
    en = 1'b0;
    exp_q = 8'h69;
  endtask

  task automatic test_random_steps();
    for (int i = 0; i < 40; i++) begin
      en = 1'($urandom); mode = 3'($urandom);
      serial_in_left = 1'($urandom); serial_in_right = 1'($urandom);
      parallel_load = 8'($urandom);
      if (en) exp_q = ref_op(mode, exp_q, serial_in_left, serial_in_right, parallel_load);
      tick();
      total_cnt++;
      if (q !== exp_q || serial_out_left !== exp_q[7] || serial_out_right !== exp_q[0] || busy !== 1'b0 || done !== 1'b0)
        $display("FAIL rand_step%0d q=%h sol=%b sor=%b busy=%b done=%b want q=%h busy=0 done=0",
                 i, q, serial_out_left, serial_out_right, busy, done, exp_q);
      else pass_cnt++;
    end
    en = 1'b0;
  endtask

  task automatic test_burst();
    logic [7:0] ev [3];
    ev = '{8'h03, 8'h07, 8'h0F};
    load_q(8'h81);
    start = 1'b1; mode = 3'd2; shift_count = 4'd3; serial_in_left = 1'b1;
    tick();
    start = 1'b0;
    total_cnt++;
    if (busy !== 1'b1 || q !== 8'h81 || done !== 1'b0) $display("FAIL burst_accept busy=%b q=%h done=%b want 1/81/0", busy, q, done);
    else pass_cnt++;
    for (int k = 0; k < 3; k++) begin
      mode = 3'($urandom); en = 1'($urandom); start = 1'($urandom);
      parallel_load = 8'($urandom); shift_count = 4'($urandom);
      tick();
      total_cnt++;
      if (q !== ev[k] || busy !== (k < 2) || done !== (k == 2))
        $display("FAIL burst_op%0d q=%h busy=%b done=%b want %h/%b/%b", k, q, busy, done, ev[k], k < 2, k == 2);
      else pass_cnt++;
    end
    start = 1'b0; en = 1'b0;
    tick();
    total_cnt++;
    if (done !== 1'b0 || busy !== 1'b0 || q !== 8'h0F) $display("FAIL burst_after done=%b busy=%b q=%h want 0/0/0f", done, busy, q);
    else pass_cnt++;
    exp_q = 8'h0F;
  endtask

  task automatic test_zero_count();
    logic [2:0] ms [2];
    logic [3:0] cs [2];
    ms = '{3'd2, 3'd3};
    cs = '{4'd0, 4'd5};
    for (int i = 0; i < 2; i++) begin
      start = 1'b1; mode = ms[i]; shift_count = cs[i]; parallel_load = ~exp_q; en = 1'b1;
      tick();
      start = 1'b0; en = 1'b0;
      total_cnt++;
      if (q !== exp_q || busy !== 1'b0 || done !== 1'b1) $display("FAIL noop_start%0d q=%h busy=%b done=%b want %h/0/1", i, q, busy, done, exp_q);
      else pass_cnt++;
      tick();
      total_cnt++;
      if (q !== exp_q || busy !== 1'b0 || done !== 1'b0) $display("FAIL noop_after%0d q=%h busy=%b done=%b want %h/0/0", i, q, busy, done, exp_q);
      else pass_cnt++;
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] m;
    int         n;
    load_q(8'($urandom));
    for (int b = 0; b < 6; b++) begin
      m = pick_shift_mode();
      n = (b == 0) ? 15 : $urandom_range(1, 15);
      start = 1'b1; mode = m; shift_count = 4'(n); en = 1'($urandom);
      tick();
      start = 1'b0;
      total_cnt++;
      if (busy !== 1'b1 || done !== 1'b0 || q !== exp_q) $display("FAIL b2b_accept%0d busy=%b done=%b q=%h want 1/0/%h", b, busy, done, q, exp_q);
      else pass_cnt++;
      for (int k = 1; k <= n; k++) begin
        serial_in_left = 1'($urandom); serial_in_right = 1'($urandom);
        mode = 3'($urandom); en = 1'($urandom);
        exp_q = ref_op(m, exp_q, serial_in_left, serial_in_right, 8'd0);
        tick();
        total_cnt++;
        if (q !== exp_q || busy !== (k < n) || done !== (k == n))
          $display("FAIL b2b_burst%0d_op%0d q=%h busy=%b done=%b want %h/%b/%b", b, k, q, busy, done, exp_q, k < n, k == n);
        else pass_cnt++;
      end
    end
    en = 1'b0;
    tick();
    total_cnt++;
    if (busy !== 1'b0 || done !== 1'b0 || q !== exp_q) $display("FAIL b2b_end busy=%b done=%b q=%h want 0/0/%h", busy, done, q, exp_q);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_burst();
    logic [7:0] ev [3];
    ev = '{8'h01, 8'h03, 8'h07};
    load_q(8'h5A);
    start = 1'b1; mode = 3'd4; shift_count = 4'd5;
    tick();
    start = 1'b0;
    tick();
    total_cnt++;
    if (q !== 8'h2D || busy !== 1'b1) $display("FAIL midrst_pre q=%h busy=%b want 2d/1", q, busy);
    else pass_cnt++;
    #2; rst = 1'b0; #1;
    total_cnt++;
    if ({q, busy, done} !== 10'd0) $display("FAIL midrst q=%h busy=%b done=%b want 00/0/0", q, busy, done);
    else pass_cnt++;
    rst = 1'b1;
    start = 1'b1; mode = 3'd2; shift_count = 4'd3; serial_in_left = 1'b1;
    tick();
    start = 1'b0;
    total_cnt++;
    if (q !== 8'h00 || busy !== 1'b1 || done !== 1'b0) $display("FAIL midrst_restart q=%h busy=%b done=%b want 00/1/0", q, busy, done);
    else pass_cnt++;
    for (int k = 0; k < 3; k++) begin
      tick();
      total_cnt++;
      if (q !== ev[k] || busy !== (k < 2) || done !== (k == 2))
        $display("FAIL midrst_op%0d q=%h busy=%b done=%b want %h/%b/%b", k, q, busy, done, ev[k], k < 2, k == 2);
      else pass_cnt++;
    end
    exp_q = 8'h07;
  endtask

  initial begin
    pass_cnt = 0;
    total_cnt = 0;
    test_reset();
    test_async_reset();
    test_load_hold();
    test_single_steps();
    test_random_steps();
    test_burst();
    test_zero_count();
    test_back_to_back();
    test_reset_mid_burst();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/param_universal_shift_reg.md
PARAM_UNIVERSAL_SHIFT_REG -- requirements
Module: param_universal_shift_reg

Interface
REQ-001 Parameter WIDTH, default 8: register width in bits; legal range 2 to 64.
REQ-002 Parameter CNT_W, default 4: width of the burst shift-count port.
REQ-003 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port rst  input  1  asynchronous, active-low reset.
REQ-005 Port en  input  1  single-step enable, honoured only in IDLE.
REQ-006 Port mode  input  3  operation select, encoded per REQ-012.
REQ-007 Port serial_in_left  input  1  bit entering at the LSB on a left shift.
REQ-008 Port serial_in_right  input  1  bit entering at the MSB on a logical right shift.
REQ-009 Port parallel_load  input  WIDTH  load data for mode 011.
REQ-010 Port start / shift_count  input / input  1 / CNT_W  burst request and burst length.
REQ-011 Ports q (WIDTH), serial_out_left (1) = q[WIDTH-1], serial_out_right (1) = q[0], busy (1), done (1); all outputs.

Function
REQ-012 The mode encoding SHALL be as follows:
- 000 hold
- 001 logical shift right, MSB <= serial_in_right
- 010 shift left, LSB <= serial_in_left
- 011 parallel load
- 100 rotate right
- 101 rotate left
- 110 arithmetic shift right, MSB preserved
- 111 clear to zero
REQ-013 Shift-class modes SHALL be 001, 010, 100, 101 and 110.
REQ-014 The FSM SHALL have exactly two states, IDLE and BUSY.
REQ-015 In IDLE with start=0 and en=1, the op selected by mode SHALL be applied to q at the next edge; with en=0, q holds.
REQ-016 In IDLE, start=1 SHALL take priority over en.
REQ-017 In IDLE, start=1 with a shift-class mode and shift_count=N>0 SHALL:
- latch mode and N at that edge
- leave q unchanged at that edge
- enter BUSY
REQ-018 In BUSY, the latched op SHALL be applied once per edge for exactly N edges; serial_in_left and serial_in_right are sampled live at each edge.
REQ-019 In BUSY, en, mode, start, shift_count and parallel_load SHALL be ignored.
REQ-020 busy SHALL be 1 exactly while in BUSY (N cycles); the FSM returns to IDLE at the edge applying the Nth op.
REQ-021 At that same edge, done SHALL be set; done stays 1 for exactly one cycle.
REQ-022 In IDLE, start=1 with shift_count=0 or a non-shift-class mode SHALL leave q unchanged, never assert busy, and pulse done for one cycle after that edge.
REQ-023 A new start SHALL be accepted in the cycle where done=1; back-to-back bursts have no idle gap beyond that cycle.
REQ-024 The maximum burst length SHALL be 2^CNT_W-1; N >= WIDTH is legal, and shifts/rotates continue modulo behaviour naturally.
REQ-025 serial_out_left and serial_out_right SHALL be combinational from q, with no added latency.

Reset
REQ-026 rst=0 SHALL immediately, independent of clk, force q=0, busy=0, done=0, the FSM to IDLE and the internal count to 0.
REQ-027 Reset asserted mid-burst SHALL abort the burst with no done pulse; operation resumes from IDLE at the first edge after rst=1.

Verification (WIDTH=8, CNT_W=4)
REQ-028 q=8'h3C, drive rst=0 between edges -> q=8'h00, busy=0 and done=0 before the next clk edge.
REQ-029 mode=011, parallel_load=8'hA5, en=1 -> q=8'hA5 after one edge; then mode=000 -> q stays 8'hA5 for 3 edges; en=0 with mode=111 -> q unchanged.
REQ-030 From q=8'hA5, apply single steps in order:
- rotr -> 8'hD2
- rotl -> 8'hA5
- asr -> 8'hD2
- shr with serial_in_right=0 -> 8'h69
REQ-031 Burst shift left from q=8'h81, serial_in_left=1, shift_count=3:
- busy=1 for exactly 3 cycles
- q passes 8'h03, 8'h07, 8'h0F
- done=1 for one cycle, with busy=0
- toggling mode/en during the burst has no effect
REQ-032 start with shift_count=0, mode=010 -> q unchanged, busy stays 0, done pulses once.
REQ-033 Assert rst=0 during the second cycle of a 5-step rotate burst -> q=0, no done; a new burst started at that point runs normally.
